// File: rtl/mac_ifmaps_feeder.sv
// Ifmap band walker: gathers 5 vertical pixels per column and
// pushes them as one entry into the MAC ifmaps FIFO.
module mac_ifmaps_feeder #(
  parameter int DATA_WIDTH = 1,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row0_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row1_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row2_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row3_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row4_in,
  output logic                  ifmaps_input_valid,
  input  logic                  fifo_full
);

  function automatic int clogb2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

  localparam int RW = clogb2(IMG_H);
  localparam int CW = clogb2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 5);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PUSH,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [2:0]            k_q, k_d;
  logic [DATA_WIDTH-1:0] row_q [5];
  logic [DATA_WIDTH-1:0] row_d [5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < 5; i++)
        row_q[i] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      for (int i = 0; i < 5; i++)
        row_q[i] <= row_d[i];
    end
  end

  always_comb begin
    state_d            = state_q;
    r_d                = r_q;
    c_d                = c_q;
    k_d                = k_q;
    for (int i = 0; i < 5; i++)
      row_d[i] = row_q[i];
    mem_en             = 1'b0;
    mem_addr           = '0;
    ifmaps_input_valid = 1'b0;
    done               = 1'b0;
    busy               = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        r_d = '0;
        c_d = '0;
        k_d = '0;
        if (start) state_d = READ;
      end
      READ: begin
        if (k_q < 3'd5) begin
          mem_en   = 1'b1;
          mem_addr = ADDR_WIDTH'(
            (32'(r_q) + 32'(k_q)) * 32'(IMG_W)
            + 32'(c_q));
        end
        // data for step k-1 returns during step k
        for (int i = 0; i < 5; i++)
          if (k_q == 3'(i + 1)) row_d[i] = mem_rdata;
        if (k_q == 3'd5) begin
          k_d     = '0;
          state_d = PUSH;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      PUSH: begin
        ifmaps_input_valid = ~fifo_full;
        if (!fifo_full) begin
          if (c_q < C_LAST) begin
            c_d     = c_q + 1'b1;
            state_d = READ;
          end else if (r_q < R_LAST) begin
            c_d     = '0;
            r_d     = r_q + 1'b1;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ifmaps_fifo_row0_in = row_q[0];
  assign ifmaps_fifo_row1_in = row_q[1];
  assign ifmaps_fifo_row2_in = row_q[2];
  assign ifmaps_fifo_row3_in = row_q[3];
  assign ifmaps_fifo_row4_in = row_q[4];

endmodule

// File: tb/tb_mac_ifmaps_feeder.sv
// Scoreboard bench for mac_ifmaps_feeder: two instances
// (8b 4x6 image with mem[a]=a, and 1b 3x5 minimum-height image).
module tb_mac_ifmaps_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          cyc;
    logic [39:0] lanes;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, full_a = 1'b0;
  logic       busy_a, done_a, en_a, val_a;
  logic [9:0] addr_a;
  logic [7:0] rdata_a = '0;
  logic [7:0] la0, la1, la2, la3, la4;

  logic       start_b = 1'b0, full_b = 1'b0;
  logic       busy_b, done_b, en_b, val_b;
  logic [9:0] addr_b;
  logic       rdata_b = 1'b0;
  logic       lb0, lb1, lb2, lb3, lb4;

  mac_ifmaps_feeder #(
    .DATA_WIDTH(8), .IMG_W(4), .IMG_H(6), .ADDR_WIDTH(10)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .busy(busy_a), .done(done_a),
    .mem_en(en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .ifmaps_fifo_row0_in(la0), .ifmaps_fifo_row1_in(la1),
    .ifmaps_fifo_row2_in(la2), .ifmaps_fifo_row3_in(la3),
    .ifmaps_fifo_row4_in(la4),
    .ifmaps_input_valid(val_a), .fifo_full(full_a)
  );

  mac_ifmaps_feeder #(
    .DATA_WIDTH(1), .IMG_W(3), .IMG_H(5), .ADDR_WIDTH(10)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .busy(busy_b), .done(done_b),
    .mem_en(en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .ifmaps_fifo_row0_in(lb0), .ifmaps_fifo_row1_in(lb1),
    .ifmaps_fifo_row2_in(lb2), .ifmaps_fifo_row3_in(lb3),
    .ifmaps_fifo_row4_in(lb4),
    .ifmaps_input_valid(val_b), .fifo_full(full_b)
  );

  // synchronous-read memories
  always @(posedge clk) rdata_a <= addr_a[7:0];
  always @(posedge clk) rdata_b <= addr_b[0] ^ addr_b[2];

  function automatic logic memb(input int a);
    logic [31:0] v;
    v = a;
    return v[0] ^ v[2];
  endfunction

  int n_valid_a = 0, n_valid_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int last_done_a = -1, last_done_b = -1;

  always @(negedge clk) begin
    exp_t e;
    if (val_a === 1'b1) begin
      n_valid_a++;
      if (full_a) check("a_valid_while_full", 1, 0);
      if (qa.size() == 0) check("a_unexpected_valid", cyc, 0);
      else begin
        e = qa.pop_front();
        check("a_lanes", {la0, la1, la2, la3, la4}, e.lanes);
        check("a_valid_cycle", cyc, e.cyc);
      end
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      last_done_a = cyc;
      check("a_busy_at_done", busy_a, 1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (val_b === 1'b1) begin
      n_valid_b++;
      if (qb.size() == 0) check("b_unexpected_valid", cyc, 0);
      else begin
        e = qb.pop_front();
        check("b_lanes", {lb0, lb1, lb2, lb3, lb4}, e.lanes);
        check("b_valid_cycle", cyc, e.cyc);
      end
    end
    if (done_b === 1'b1) begin
      done_cnt_b++;
      last_done_b = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int t, input int stall);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      int r, c;
      r = j / 4;
      c = j % 4;
      e.cyc   = t + 7 + 7 * j + stall;
      e.lanes = {8'(r * 4 + c), 8'((r + 1) * 4 + c),
                 8'((r + 2) * 4 + c), 8'((r + 3) * 4 + c),
                 8'((r + 4) * 4 + c)};
      qa.push_back(e);
    end
  endtask

  task automatic start_a_at(input int t);
    wait_cyc(t);
    start_a = 1'b1;
    wait_cyc(t + 1);
    start_a = 1'b0;
  endtask

  task automatic end_pass_a(input int t, input int stall,
                            input int v0, input int d0);
    wait_cyc(t + 60 + stall);
    check("a_done_cycle", last_done_a, t + 57 + stall);
    check("a_done_count", done_cnt_a - d0, 1);
    check("a_entry_count", n_valid_a - v0, 8);
    check("a_queue_drained", qa.size(), 0);
    check("a_busy_after", busy_a, 0);
  endtask

  task automatic chk_zero_a(input string name);
    check(name, {busy_a, done_a, en_a, addr_a, val_a,
                 la0, la1, la2, la3, la4}, 0);
  endtask

  initial begin
    int t, v0, d0;
    exp_t e;
    wait_cyc(2);
    @(negedge clk);
    chk_zero_a("a_reset_state");
    check("b_reset_state", {busy_b, done_b, en_b, addr_b,
                            val_b, lb0, lb1, lb2, lb3, lb4}, 0);
    wait_cyc(3);
    rst_n = 1'b1;

    // basic pass with address sequence
    t = 10; v0 = n_valid_a; d0 = done_cnt_a;
    push_a(t, 0);
    start_a_at(t);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i <= 5) check("a_mem_addr", {en_a, addr_a},
                        {1'b1, 10'((i - 1) * 4)});
      else check("a_mem_en_off", en_a, 0);
    end
    end_pass_a(t, 0, v0, d0);

    // backpressure on the first entry
    t = 80; v0 = n_valid_a; d0 = done_cnt_a;
    push_a(t, 3);
    start_a_at(t);
    wait_cyc(t + 6);
    full_a = 1'b1;
    wait_cyc(t + 10);
    full_a = 1'b0;
    end_pass_a(t, 3, v0, d0);

    // start while busy is ignored
    t = 150; v0 = n_valid_a; d0 = done_cnt_a;
    push_a(t, 0);
    start_a_at(t);
    wait_cyc(t + 20);
    start_a = 1'b1;
    wait_cyc(t + 21);
    start_a = 1'b0;
    end_pass_a(t, 0, v0, d0);

    // reset in mid-pass
    t = 220; d0 = done_cnt_a;
    push_a(t, 0);
    start_a_at(t);
    wait_cyc(t + 30);
    rst_n = 1'b0;
    wait_cyc(t + 31);
    @(negedge clk);
    chk_zero_a("a_zero_in_reset");
    check("a_aborted_left", qa.size(), 4);
    qa.delete();
    wait_cyc(t + 32);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_zero_a("a_zero_after_reset");
    end
    check("a_no_done_on_abort", done_cnt_a - d0, 0);

    t = 270; v0 = n_valid_a; d0 = done_cnt_a;
    push_a(t, 0);
    start_a_at(t);
    end_pass_a(t, 0, v0, d0);

    // minimum height on the 1-bit instance
    t = 340; v0 = n_valid_b; d0 = done_cnt_b;
    for (int c = 0; c < 3; c++) begin
      e.cyc   = t + 7 + 7 * c;
      e.lanes = 40'({memb(c), memb(3 + c), memb(6 + c),
                     memb(9 + c), memb(12 + c)});
      qb.push_back(e);
    end
    wait_cyc(t);
    start_b = 1'b1;
    wait_cyc(t + 1);
    start_b = 1'b0;
    wait_cyc(t + 26);
    check("b_done_cycle", last_done_b, t + 22);
    check("b_done_count", done_cnt_b - d0, 1);
    check("b_entry_count", n_valid_b - v0, 3);
    check("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_ifmaps_feeder.md
# mac_ifmaps_feeder

Write-side producer for the MAC ifmaps FIFO. It walks an ifmap stored pixel-per-word in a single-port synchronous-read memory. For each 5-row band (stride 1) and each column, it gathers the 5 vertically adjacent pixels and pushes them as one FIFO entry on the five `ifmaps_fifo_rowK_in` lanes. It sits between the ifmap buffer and the FIFO, with backpressure taken from `fifo_full`.

## Interface
- `DATA_WIDTH`, default 1: pixel width; also the width of each FIFO lane.
- `IMG_W`, default 32: image width in pixels.
- `IMG_H`, default 32: image height in pixels. Must be at least 5.
- `ADDR_WIDTH`, default 10: memory address width. Must satisfy 2^ADDR_WIDTH ≥ IMG_W*IMG_H.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a full-image pass. Ignored while `busy`=1.
- `busy` out 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` out 1: one-cycle pulse after the last entry is accepted.
- `mem_en` out 1: memory read enable.
- `mem_addr` out ADDR_WIDTH: read address, row-major; pixel (r,c) is at r*IMG_W + c.
- `mem_rdata` in DATA_WIDTH: read data, valid the cycle after `mem_en`=1.
- `ifmaps_fifo_row0_in` … `ifmaps_fifo_row4_in` out DATA_WIDTH each: pixel rows r+0 … r+4 of the current column.
- `ifmaps_input_valid` out 1: FIFO write strobe.
- `fifo_full` in 1: FIFO full flag.

## Operation
- FSM states: IDLE, READ, PUSH, DONE.
- **IDLE**
  - On `start`=1, go to READ.
  - Clear the band counter `r`=0 and the column counter `c`=0.
- **READ** (6 cycles, step k=0..5)
  - Steps k=0..4: `mem_en`=1 and `mem_addr`=(r+k)*IMG_W + c.
  - Steps k=1..5: latch `mem_rdata` into row register k-1.
  - After k=5, go to PUSH.
- **PUSH**
  - `ifmaps_input_valid` = (state==PUSH) & ~`fifo_full`. This is a combinational gate; the entry transfers in that same cycle.
  - The feeder never asserts valid while `fifo_full`=1. It does not rely on the FIFO's simultaneous read/write path.
  - Row lanes stay stable for the whole PUSH state.
  - On transfer:
    - If c < IMG_W-1: increment c, then go to READ.
    - Else if r < IMG_H-5: set c=0, increment r, then go to READ.
    - Else go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Counter widths: `r` and `c` are sized with clogb2 from IMG_H and IMG_W.
- Address arithmetic is unsigned and computed at full width before truncation to ADDR_WIDTH. There is no wrap within a pass.
- Total entries per pass = (IMG_H-4)*IMG_W, ordered band-major, column-minor.
- `start` during `busy` has no effect.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - state to IDLE; `r`, `c` and the step counter to 0;
  - `busy`, `done`, `mem_en`, `ifmaps_input_valid` to 0;
  - `mem_addr` to 0 and all row lanes to 0.
- Reset mid-pass aborts the pass. No `done` is issued, and no further valid is driven until the next `start`.
- Schedule for `start` sampled in cycle T, with column index j counted from 0 across the pass:
  - READ occupies T+1+7j … T+6+7j.
  - PUSH begins at T+7+7j.
  - Each cycle of `fifo_full`=1 in PUSH adds exactly one cycle.
- Without stalls:
  - Per entry: 7 cycles.
  - `done` at T+1+7N, where N = (IMG_H-4)*IMG_W.
  - `busy` is high over T+1 … T+1+7N.
- `mem_rdata` is sampled exactly one cycle after its address. A `fifo_full` stall happens only in PUSH, so it never disturbs a read in flight.

## Test plan
- **Basic pass.** DATA_WIDTH=8, IMG_W=4, IMG_H=6, mem[a]=a; `start` at T, `fifo_full`=0.
  - Exactly 8 valids, at T+7, T+14, … T+56.
  - First entry lanes = 0, 4, 8, 12, 16.
  - Last entry lanes = 7, 11, 15, 19, 23.
  - `done` at T+57.
- **Backpressure.** Same setup, with `fifo_full`=1 for cycles T+7 … T+9.
  - No valid while full; first valid at T+10 with lanes 0, 4, 8, 12, 16.
  - `done` at T+60.
- **Address sequence.** Check `mem_addr` over T+1 … T+5 = 0, 4, 8, 12, 16 with `mem_en`=1, and `mem_en`=0 at T+6 and T+7.
- **Ignored start.** A `start` pulse while `busy` (e.g. at T+20) leaves the entry count at 8 and `done` at T+57.
- **Mid-pass reset.** `rst_n`=0 at T+30, released at T+32.
  - From T+31 on: all outputs 0, no `done`.
  - A fresh `start` reproduces the basic-pass sequence.
- **Minimum height.** DATA_WIDTH=1, IMG_W=3, IMG_H=5: exactly 3 entries, then `done` at T+22.
